// File: rtl/sha512_msg_schedule.sv
// sha512_msg_schedule: SHA-512 W0..W(ROUNDS-1) generator over a 16-word sliding window.
// Optional round_idx output under SHA512_SCHED_ROUND_OUT_EN.
module sha512_msg_schedule #(
  parameter int ROUNDS = 80
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1023:0] M,
  output logic          w_valid,
  input  logic          w_ready,
  output logic [63:0]   Wj,
  output logic          done
`ifdef SHA512_SCHED_ROUND_OUT_EN
  ,
  output logic [6:0]    round_idx
`endif
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e      state_q, state_d;
  logic [6:0]  t_q, t_d;
  logic [63:0] w_q [16];
  logic [63:0] w_d [16];
  logic        done_q, done_d;
  logic        xfer, last;
  logic [63:0] w_new;
  function automatic logic [63:0] s0(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction
  always_comb begin
    xfer    = (state_q == RUN) && w_ready;
    last    = t_q == 7'(ROUNDS - 1);
    w_new   = s1(w_q[14]) + w_q[9] + s0(w_q[1]) + w_q[0];
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    done_d  = 1'b0;
    if (state_q == IDLE && in_valid) begin
      state_d = RUN;
      t_d     = '0;
      for (int k = 0; k < 16; k++) w_d[k] = M[1023-64*k -: 64];
    end else if (xfer && last) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (xfer) begin
      t_d = t_q + 7'd1;
      for (int k = 0; k < 15; k++) w_d[k] = w_q[k+1];
      w_d[15] = w_new;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < 16; k++) w_q[k] <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      done_q  <= done_d;
      w_q     <= w_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign w_valid  = state_q == RUN;
  assign Wj       = w_valid ? w_q[0] : '0;
  assign done     = done_q;
`ifdef SHA512_SCHED_ROUND_OUT_EN
  assign round_idx = w_valid ? t_q : '0;
`endif
endmodule

// File: tb/tb_sha512_msg_schedule.sv
// tb_sha512_msg_schedule: scoreboard bench for the 80-round and 20-round schedule builds.
module tb_sha512_msg_schedule;
  logic          clk = 0, rst = 1;
  logic          iv = 0, rdy, wv, wr = 0, dn;
  logic [1023:0] M = '0;
  logic [63:0]   W;
  logic          iv2 = 0, rdy2, wv2, wr2 = 0, dn2;
  logic [1023:0] M2 = '0;
  logic [63:0]   W2;
`ifdef SHA512_SCHED_ROUND_OUT_EN
  logic [6:0]    ridx2;
`endif
  logic [63:0]   q [$];
  logic [63:0]   q2 [$];
  int            cmp = 0, bad = 0;
  logic [1023:0] abc, ones;

  always #5 clk = ~clk;

  sha512_msg_schedule #(.ROUNDS(80)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(rdy), .M(M),
    .w_valid(wv), .w_ready(wr), .Wj(W), .done(dn));
  sha512_msg_schedule #(.ROUNDS(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(rdy2), .M(M2),
    .w_valid(wv2), .w_ready(wr2), .Wj(W2), .done(dn2)
`ifdef SHA512_SCHED_ROUND_OUT_EN
    , .round_idx(ridx2)
`endif
  );

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  task automatic gen(input logic [1023:0] blk, input int n, input bit second);
    logic [63:0] w [80];
    for (int t = 0; t < n; t++) begin
      if (t < 16) w[t] = blk[1023-64*t -: 64];
      else w[t] = w[t-16] + (rotr(w[t-15], 1) ^ rotr(w[t-15], 8) ^ (w[t-15] >> 7))
                + w[t-7] + (rotr(w[t-2], 19) ^ rotr(w[t-2], 61) ^ (w[t-2] >> 6));
      if (second) q2.push_back(w[t]); else q.push_back(w[t]);
    end
  endtask

  task automatic load(input logic [1023:0] blk);
    @(negedge clk);
    M = blk; iv = 1;
    gen(blk, 80, 0);
    @(negedge clk);
    iv = 0;
  endtask

  function automatic logic [1023:0] rnd_blk();
    logic [1023:0] b;
    for (int k = 0; k < 32; k++) b[k*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [63:0] pop1();
    return q.size() > 0 ? q.pop_front() : 64'bx;
  endfunction

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    cmp += 5;
    if (rdy !== 1 || wv !== 0 || dn !== 0 || W !== 0) begin
      bad++; $display("FAIL reset: rdy=%b wv=%b done=%b Wj=%h, want 1 0 0 0", rdy, wv, dn, W);
    end
    if (rdy2 !== 1 || wv2 !== 0 || dn2 !== 0 || W2 !== 0) begin
      bad++; $display("FAIL reset20: rdy=%b wv=%b done=%b Wj=%h, want 1 0 0 0", rdy2, wv2, dn2, W2);
    end
    rst = 0;
  endtask

  task automatic test_abc();
    logic [63:0] e;
    wr = 1;
    load(abc);
    for (int i = 0; i < 80; i++) begin
      e = pop1();
      cmp += 3;
      if (wv !== 1 || W !== e) begin
        bad++; $display("FAIL abc W%0d: wv=%b Wj=%h, want 1 %h", i, wv, W, e);
      end
      if (dn !== 0) begin bad++; $display("FAIL abc early done at W%0d", i); end
      if (i == 16 && W !== 64'h6162638000000000) begin
        bad++; $display("FAIL abc W16 const: %h want 6162638000000000", W);
      end
      if (i == 17 && W !== 64'h00030000000000C0) begin
        bad++; $display("FAIL abc W17 const: %h want 00030000000000c0", W);
      end
      @(negedge clk);
    end
    cmp++;
    if (dn !== 1 || wv !== 0 || rdy !== 1) begin
      bad++; $display("FAIL abc end: done=%b wv=%b rdy=%b, want 1 0 1", dn, wv, rdy);
    end
    @(negedge clk);
    cmp++;
    if (dn !== 0) begin bad++; $display("FAIL abc done width: done=%b want 0", dn); end
  endtask

  task automatic test_backpressure();
    int cnt = 0;
    bit stall = 0;
    logic [63:0] held = '0, e;
    wr = 0;
    load(abc);
    for (int c = 0; c < 2000 && cnt < 80; c++) begin
      if (wv) begin
        if (stall) begin
          cmp++;
          if (W !== held) begin bad++; $display("FAIL bp stable: Wj=%h want %h", W, held); end
        end
        wr = 1'($urandom % 2);
        if (wr) begin
          e = pop1();
          cmp++;
          if (W !== e) begin bad++; $display("FAIL bp W%0d: Wj=%h want %h", cnt, W, e); end
          cnt++; stall = 0;
        end else begin
          stall = 1; held = W;
        end
      end
      @(negedge clk);
    end
    cmp += 2;
    if (cnt !== 80) begin bad++; $display("FAIL bp count: %0d transfers want 80", cnt); end
    if (dn !== 1) begin bad++; $display("FAIL bp done: done=%b want 1", dn); end
    wr = 0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [1023:0] b = rnd_blk();
    logic [63:0] e;
    wr = 1;
    load(abc);
    for (int i = 0; i < 80; i++) begin
      if (i == 5) begin iv = 1; M = b; end
      e = pop1();
      cmp += 2;
      if (W !== e) begin bad++; $display("FAIL b2b A W%0d: Wj=%h want %h", i, W, e); end
      if (rdy !== 0) begin bad++; $display("FAIL b2b in_ready during run: %b want 0", rdy); end
      @(negedge clk);
    end
    cmp++;
    if (dn !== 1 || rdy !== 1) begin
      bad++; $display("FAIL b2b done cycle: done=%b rdy=%b want 1 1", dn, rdy);
    end
    gen(b, 80, 0);
    @(negedge clk);
    iv = 0;
    for (int i = 0; i < 80; i++) begin
      e = pop1();
      cmp++;
      if (wv !== 1 || W !== e) begin bad++; $display("FAIL b2b B W%0d: wv=%b Wj=%h want 1 %h", i, wv, W, e); end
      @(negedge clk);
    end
    cmp++;
    if (dn !== 1) begin bad++; $display("FAIL b2b B done: %b want 1", dn); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [63:0] e;
    wr = 1;
    load(rnd_blk());
    for (int i = 0; i <= 40; i++) begin
      e = pop1();
      cmp++;
      if (W !== e) begin bad++; $display("FAIL rstmid W%0d: Wj=%h want %h", i, W, e); end
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    q.delete();
    cmp++;
    if (wv !== 0 || rdy !== 1 || W !== 0 || dn !== 0) begin
      bad++; $display("FAIL rstmid state: wv=%b rdy=%b Wj=%h done=%b want 0 1 0 0", wv, rdy, W, dn);
    end
    @(negedge clk);
    cmp++;
    if (dn !== 0 || wv !== 0) begin bad++; $display("FAIL rstmid late: done=%b wv=%b want 0 0", dn, wv); end
    load(rnd_blk());
    for (int i = 0; i < 80; i++) begin
      e = pop1();
      cmp++;
      if (wv !== 1 || W !== e) begin bad++; $display("FAIL rstmid restart W%0d: Wj=%h want %h", i, W, e); end
      @(negedge clk);
    end
    cmp++;
    if (dn !== 1) begin bad++; $display("FAIL rstmid restart done: %b want 1", dn); end
    @(negedge clk);
  endtask

  task automatic test_sigma();
    logic [63:0] e;
    wr = 1;
    load(ones);
    for (int i = 0; i < 80; i++) begin
      e = pop1();
      cmp++;
      if (W !== e) begin bad++; $display("FAIL sigma W%0d: Wj=%h want %h", i, W, e); end
      if (i == 16) begin
        cmp++;
        if (W !== 64'h05FFFFFFFFFFFFFC) begin bad++; $display("FAIL sigma W16 const: %h want 05fffffffffffffc", W); end
      end
      @(negedge clk);
    end
    cmp++;
    if (dn !== 1) begin bad++; $display("FAIL sigma done: %b want 1", dn); end
    @(negedge clk);
  endtask

  task automatic test_rounds20();
    logic [1023:0] b = rnd_blk();
    logic [63:0] e;
    wr2 = 1;
    @(negedge clk);
    M2 = b; iv2 = 1;
    gen(b, 20, 1);
    @(negedge clk);
    iv2 = 0;
    for (int i = 0; i < 20; i++) begin
      e = q2.size() > 0 ? q2.pop_front() : 64'bx;
      cmp += 2;
      if (wv2 !== 1 || W2 !== e) begin bad++; $display("FAIL r20 W%0d: wv=%b Wj=%h want 1 %h", i, wv2, W2, e); end
      if (dn2 !== 0) begin bad++; $display("FAIL r20 early done at W%0d", i); end
`ifdef SHA512_SCHED_ROUND_OUT_EN
      cmp++;
      if (ridx2 !== 7'(i)) begin bad++; $display("FAIL r20 round_idx: %0d want %0d", ridx2, i); end
`endif
      @(negedge clk);
    end
    cmp++;
    if (dn2 !== 1 || wv2 !== 0 || rdy2 !== 1) begin
      bad++; $display("FAIL r20 end: done=%b wv=%b rdy=%b want 1 0 1", dn2, wv2, rdy2);
    end
`ifdef SHA512_SCHED_ROUND_OUT_EN
    cmp++;
    if (ridx2 !== 0) begin bad++; $display("FAIL r20 round_idx idle: %0d want 0", ridx2); end
`endif
    @(negedge clk);
  endtask

  initial begin
    abc = '0;
    abc[1023:960] = 64'h6162638000000000;
    abc[63:0] = 64'h18;
    ones = '1;
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_sigma();
    test_rounds20();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
